// File: rtl/alpha_razor_stream_if.sv
// Stream bundle for alpha_razor_stream: branch metrics in, normalized alphas out,
// plus razor error observation/injection and the saturating error counter.
interface alpha_razor_stream_if #(
  parameter int M    = 6,
  parameter int N    = 5,
  parameter int ErrW = 8
);
  // Valid/ready: a beat moves on a cycle where valid && ready are both high; the
  // sender holds valid and payload stable until then, and ready never looks at valid.
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_first;
  logic signed [N-1:0]    ba2;
  logic signed [M:0]      ba1ba3;
  logic signed [M:0]      ba1ba2ba3;
  logic [6:0]             razor_inject;
  logic                   out_valid;
  logic                   out_ready;
  logic [7*M-1:0]         alpha_out;
  logic                   Error_current_Alpha;
  logic [ErrW-1:0]        err_count;
  logic                   err_clr;

  modport master (
    output in_valid, in_first, ba2, ba1ba3, ba1ba2ba3, razor_inject, out_ready, err_clr,
    input  in_ready, out_valid, alpha_out, Error_current_Alpha, err_count
  );

  modport slave (
    input  in_valid, in_first, ba2, ba1ba3, ba1ba2ba3, razor_inject, out_ready, err_clr,
    output in_ready, out_valid, alpha_out, Error_current_Alpha, err_count
  );
endinterface

// File: rtl/alpha_razor_stream.sv
// Forward (alpha) recursion of an 8-state trellis with razor-style shadow checking
// of the alpha MSBs; errors are either corrected in place or replayed.
module alpha_razor_stream #(
  parameter int M        = 6,
  parameter int N        = 5,
  parameter int RazorBit = 1,
  parameter int Mode     = 0,
  parameter int ErrW     = 8
) (
  input logic                 Clock,
  input logic                 nReset,
  alpha_razor_stream_if.slave bus
);
  localparam int SW = M + 2;
  localparam int DW = M + 3;
  localparam int FB = M - RazorBit;

  localparam logic signed [M-1:0]  A_MIN = {1'b1, {(M-1){1'b0}}};
  localparam logic signed [M-1:0]  A_MAX = {1'b0, {(M-1){1'b1}}};
  localparam logic signed [DW-1:0] D_MIN = {{4{1'b1}}, {(M-1){1'b0}}};
  localparam logic signed [DW-1:0] D_MAX = {{4{1'b0}}, {(M-1){1'b1}}};
  localparam logic signed [M-1:0]  FLIP  = M'(1) << FB;

  logic signed [M-1:0]   a_q      [1:7];
  logic [RazorBit-1:0]   shadow_q [1:7];
  logic signed [M-1:0]   hold_a   [1:7];
  logic signed [M:0]     hold_abc, hold_ab;
  logic signed [N-1:0]   hold_c;
  logic                  step_valid_q, fresh_q;
  logic [ErrW-1:0]       err_count_q;

  logic                  any_mis, err, replay, fix, out_valid, in_ready, xfer, load;
  logic [7*M-1:0]        alpha_flat;
  logic signed [M-1:0]   a_eff [1:7];
  logic signed [M-1:0]   a_src [1:7];
  logic signed [M-1:0]   a_nxt [1:7];
  logic signed [M:0]     op_a, op_b;
  logic signed [N-1:0]   op_c;
  logic signed [SW-1:0]  xa, xb, xc;
  logic signed [SW-1:0]  ea [1:7];
  logic signed [SW-1:0]  m  [0:7];
  logic signed [DW-1:0]  d  [1:7];

  function automatic logic signed [SW-1:0] smax(input logic signed [SW-1:0] x,
                                                input logic signed [SW-1:0] y);
    return (y > x) ? y : x;
  endfunction

  // The shadow sample is taken at the capture edge, so without injection it always
  // agrees with the main flop; razor_inject stands in for a late-arriving bit.
  always_comb begin
    any_mis = 1'b0;
    for (int k = 1; k <= 7; k++)
      any_mis = any_mis | (shadow_q[k] != a_q[k][M-1 -: RazorBit]);
  end

  assign err       = step_valid_q && any_mis;
  assign replay    = (Mode == 1) && err;
  assign fix       = (Mode == 0) && err;
  assign out_valid = step_valid_q && !replay;
  assign in_ready  = (!out_valid || bus.out_ready) && !replay;
  assign xfer      = bus.in_valid && in_ready;
  assign load      = xfer || replay;

  assign bus.out_valid           = out_valid;
  assign bus.in_ready            = in_ready;
  assign bus.Error_current_Alpha = err;
  assign bus.err_count           = err_count_q;
  assign bus.alpha_out           = alpha_flat;

  always_comb begin
    alpha_flat = '0;
    for (int k = 1; k <= 7; k++) begin
      a_eff[k] = fix ? (a_q[k] ^ FLIP) : a_q[k];
      alpha_flat[(k-1)*M +: M] = a_eff[k];
      if (replay)            a_src[k] = hold_a[k];
      else if (bus.in_first) a_src[k] = A_MIN;
      else                   a_src[k] = a_eff[k];
    end
  end

  // A replay recomputes from the operands and state captured with the original beat.
  assign op_a = replay ? hold_abc : bus.ba1ba2ba3;
  assign op_b = replay ? hold_ab  : bus.ba1ba3;
  assign op_c = replay ? hold_c   : bus.ba2;

  always_comb begin
    xa = SW'(op_a);
    xb = SW'(op_b);
    xc = SW'(op_c);
    for (int k = 1; k <= 7; k++) ea[k] = SW'(a_src[k]);
    m[0] = smax('0, ea[1] + xa);
    m[1] = smax(ea[2] + xb, ea[3] + xc);
    m[2] = smax(ea[4] + xc, ea[5] + xb);
    m[3] = smax(ea[7], ea[6] + xa);
    m[4] = smax(xa, ea[1]);
    m[5] = smax(ea[2] + xc, ea[3] + xb);
    m[6] = smax(ea[4] + xb, ea[5] + xc);
    m[7] = smax(ea[6], ea[7] + xa);
    for (int k = 1; k <= 7; k++) begin
      d[k] = DW'(m[k]) - DW'(m[0]);
      if (d[k] > D_MAX)      a_nxt[k] = A_MAX;
      else if (d[k] < D_MIN) a_nxt[k] = A_MIN;
      else                   a_nxt[k] = d[k][M-1:0];
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      step_valid_q <= 1'b0;
      fresh_q      <= 1'b0;
      hold_abc     <= '0;
      hold_ab      <= '0;
      hold_c       <= '0;
      for (int k = 1; k <= 7; k++) begin
        a_q[k]      <= '0;
        shadow_q[k] <= '0;
        hold_a[k]   <= '0;
      end
    end else begin
      fresh_q <= load;
      if (load) begin
        step_valid_q <= 1'b1;
        for (int k = 1; k <= 7; k++) begin
          a_q[k]      <= a_nxt[k];
          shadow_q[k] <= a_nxt[k][M-1 -: RazorBit] ^ RazorBit'(bus.razor_inject[k-1]);
        end
      end else if (out_valid && bus.out_ready) begin
        step_valid_q <= 1'b0;
      end
      if (xfer) begin
        hold_abc <= bus.ba1ba2ba3;
        hold_ab  <= bus.ba1ba3;
        hold_c   <= bus.ba2;
        for (int k = 1; k <= 7; k++) hold_a[k] <= a_src[k];
      end
    end
  end

  // Counted only on the first cycle a step is registered, so a stalled error counts once.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)
      err_count_q <= '0;
    else if (bus.err_clr)
      err_count_q <= '0;
    else if (err && fresh_q && (err_count_q != '1))
      err_count_q <= err_count_q + ErrW'(1);
  end
endmodule

// File: tb/tb_alpha_razor_stream.sv
// Directed bench for alpha_razor_stream: one correct-in-place and one replay instance,
// hand-computed alpha vectors checked in order through an expected queue.
module tb_alpha_razor_stream;
  localparam int M  = 6;
  localparam int N  = 5;
  localparam int RB = 1;
  localparam int EW = 8;

  logic Clock = 1'b0;
  logic nReset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7*M-1:0] exp_q[$];

  alpha_razor_stream_if #(.M(M), .N(N), .ErrW(EW)) if0 ();
  alpha_razor_stream_if #(.M(M), .N(N), .ErrW(EW)) if1 ();

  alpha_razor_stream #(.M(M), .N(N), .RazorBit(RB), .Mode(0), .ErrW(EW)) u_dut0 (
    .Clock(Clock), .nReset(nReset), .bus(if0)
  );
  alpha_razor_stream #(.M(M), .N(N), .RazorBit(RB), .Mode(1), .ErrW(EW)) u_dut1 (
    .Clock(Clock), .nReset(nReset), .bus(if1)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs seven signed alphas, state 1 in the least significant field.
  function automatic logic [7*M-1:0] pk(input int v1, input int v2, input int v3, input int v4,
                                        input int v5, input int v6, input int v7);
    int             arr[7];
    logic [7*M-1:0] r;
    arr = '{v1, v2, v3, v4, v5, v6, v7};
    r = '0;
    for (int k = 6; k >= 0; k--) r = (r << M) | (7*M)'(arr[k] & ((1 << M) - 1));
    return r;
  endfunction

  task automatic drive(input int u, input logic v, input logic f, input int a, input int b,
                       input int c, input logic [6:0] inj);
    if (u == 0) begin
      if0.in_valid = v; if0.in_first = f; if0.razor_inject = inj;
      if0.ba1ba2ba3 = (M+1)'(a); if0.ba1ba3 = (M+1)'(b); if0.ba2 = N'(c);
    end else begin
      if1.in_valid = v; if1.in_first = f; if1.razor_inject = inj;
      if1.ba1ba2ba3 = (M+1)'(a); if1.ba1ba3 = (M+1)'(b); if1.ba2 = N'(c);
    end
  endtask

  task automatic chk_alpha(input int u, input string tag);
    logic [7*M-1:0] obs;
    logic [7*M-1:0] e;
    obs = (u == 0) ? if0.alpha_out : if1.alpha_out;
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk(tag, 64'(obs), 64'(e));
  endtask

  initial begin
    nReset = 1'b0;
    drive(0, 1'b0, 1'b0, 0, 0, 0, 7'd0);
    drive(1, 1'b0, 1'b0, 0, 0, 0, 7'd0);
    if0.out_ready = 1'b1; if1.out_ready = 1'b1;
    if0.err_clr   = 1'b0; if1.err_clr   = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 64'(if0.out_valid), 64'(0));
    chk("rst_alpha", 64'(if0.alpha_out), 64'(0));
    chk("rst_error", 64'(if0.Error_current_Alpha), 64'(0));
    chk("rst_err_count", 64'(if0.err_count), 64'(0));
    chk("rst_out_valid_m1", 64'(if1.out_valid), 64'(0));
    nReset = 1'b1;
    #1;
    chk("rst_in_ready", 64'(if0.in_ready), 64'(1));

    // zero state, A=5 B=3 C=-2
    drive(0, 1'b1, 1'b0, 5, 3, -2, 7'd0);
    exp_q.push_back(pk(-2, -2, 0, 0, -2, -2, 0));
    tick();
    chk("basic_valid", 64'(if0.out_valid), 64'(1));
    chk_alpha(0, "basic_alpha");
    chk("basic_error", 64'(if0.Error_current_Alpha), 64'(0));

    // in_first with zero metrics: m4 = max(A, a1) = 0 keeps state 4 at 0
    drive(0, 1'b1, 1'b1, 0, 0, 0, 7'd0);
    exp_q.push_back(pk(-32, -32, -32, 0, -32, -32, -32));
    tick();
    chk_alpha(0, "first_init_alpha");

    // both saturation directions: m1-m0 = -79 -> -32, m4-m0 = 32 -> 31
    drive(0, 1'b1, 1'b1, 63, -64, -16, 7'd0);
    exp_q.push_back(pk(-32, -32, 0, 31, -32, -32, 0));
    tick();
    chk_alpha(0, "saturate_alpha");

    // chained from the saturated state
    drive(0, 1'b1, 1'b0, -7, 4, 9, 7'd0);
    exp_q.push_back(pk(9, 31, 0, -7, 4, 31, -7));
    tick();
    chk_alpha(0, "chain_alpha");

    // backpressure for three cycles with a beat waiting
    if0.out_ready = 1'b0;
    drive(0, 1'b1, 1'b0, 0, 0, 0, 7'd0);
    #1;
    chk("bp_in_ready", 64'(if0.in_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready_hold", 64'(if0.in_ready), 64'(0));
      chk("bp_out_valid", 64'(if0.out_valid), 64'(1));
      chk("bp_alpha_stable", 64'(if0.alpha_out), 64'(pk(9, 31, 0, -7, 4, 31, -7)));
    end
    if0.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(if0.in_ready), 64'(1));
    exp_q.push_back(pk(22, -5, 22, 0, 22, -5, 22));
    tick();
    chk_alpha(0, "bp_next_alpha");
    drive(0, 1'b0, 1'b0, 0, 0, 0, 7'd0);
    tick();
    chk("drain_out_valid", 64'(if0.out_valid), 64'(0));

    // correct-in-place: all seven bit-5 flips show on the output and in the feedback
    drive(0, 1'b1, 1'b1, 0, 0, 0, 7'b0000001);
    exp_q.push_back(pk(0, 0, 0, -32, 0, 0, 0));
    tick();
    chk("m0_error_flag", 64'(if0.Error_current_Alpha), 64'(1));
    chk("m0_out_valid", 64'(if0.out_valid), 64'(1));
    chk_alpha(0, "m0_flipped_alpha");
    drive(0, 1'b1, 1'b0, 0, 0, 0, 7'd0);
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0));
    tick();
    chk_alpha(0, "m0_corrected_feedback");
    chk("m0_error_clear", 64'(if0.Error_current_Alpha), 64'(0));
    chk("m0_err_count", 64'(if0.err_count), 64'(1));
    drive(0, 1'b0, 1'b0, 0, 0, 0, 7'd0);
    if0.err_clr = 1'b1;
    tick();
    if0.err_clr = 1'b0;
    chk("m0_err_clr", 64'(if0.err_count), 64'(0));

    // stall-and-replay: bubble, then the corrected step, then the waiting beat
    drive(1, 1'b1, 1'b0, 5, 3, -2, 7'b0000001);
    exp_q.push_back(pk(-2, -2, 0, 0, -2, -2, 0));
    tick();
    drive(1, 1'b1, 1'b1, 0, 0, 0, 7'd0);
    #1;
    chk("m1_error_flag", 64'(if1.Error_current_Alpha), 64'(1));
    chk("m1_valid_low", 64'(if1.out_valid), 64'(0));
    chk("m1_ready_low", 64'(if1.in_ready), 64'(0));
    exp_q.push_back(pk(-32, -32, -32, 0, -32, -32, -32));
    tick();
    chk("m1_replay_valid", 64'(if1.out_valid), 64'(1));
    chk_alpha(1, "m1_replay_alpha");
    chk("m1_ready_back", 64'(if1.in_ready), 64'(1));
    chk("m1_error_gone", 64'(if1.Error_current_Alpha), 64'(0));
    tick();
    chk_alpha(1, "m1_order_alpha");
    chk("m1_err_count", 64'(if1.err_count), 64'(1));

    // error again during the replay: a second replay, still one output
    drive(1, 1'b1, 1'b0, 0, 0, 0, 7'b0000001);
    exp_q.push_back(pk(-32, 0, -32, 0, -32, 0, -32));
    tick();
    drive(1, 1'b0, 1'b0, 0, 0, 0, 7'b0000001);
    chk("m1_double_valid_low1", 64'(if1.out_valid), 64'(0));
    tick();
    drive(1, 1'b0, 1'b0, 0, 0, 0, 7'd0);
    chk("m1_double_valid_low2", 64'(if1.out_valid), 64'(0));
    chk("m1_double_error", 64'(if1.Error_current_Alpha), 64'(1));
    tick();
    chk("m1_double_valid", 64'(if1.out_valid), 64'(1));
    chk_alpha(1, "m1_double_alpha");
    chk("m1_double_count", 64'(if1.err_count), 64'(3));
    tick();
    chk("m1_drain_valid", 64'(if1.out_valid), 64'(0));

    // reset while a step is held by backpressure discards it and the state
    if0.out_ready = 1'b0;
    drive(0, 1'b1, 1'b1, 0, 0, 0, 7'd0);
    tick();
    chk("rbp_held_valid", 64'(if0.out_valid), 64'(1));
    drive(0, 1'b0, 1'b0, 0, 0, 0, 7'd0);
    nReset = 1'b0;
    #1;
    chk("rbp_out_valid", 64'(if0.out_valid), 64'(0));
    chk("rbp_alpha", 64'(if0.alpha_out), 64'(0));
    #2;
    nReset = 1'b1;
    if0.out_ready = 1'b1;
    drive(0, 1'b1, 1'b0, 5, 3, -2, 7'd0);
    exp_q.push_back(pk(-2, -2, 0, 0, -2, -2, 0));
    tick();
    chk_alpha(0, "rbp_fresh_state_alpha");
    drive(0, 1'b0, 1'b0, 0, 0, 0, 7'd0);
    tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
